// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: first-word-fall-through stream FIFO with a LAST sideband, level flags,
// synchronous flush and an optional packet mode that holds output until a full burst
// (terminated by LAST) is stored.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               synchronous clear of contents (reset has priority)
//   vld_in/rdy_in       upstream handshake, data_in payload, last_in end-of-packet
//   vld_out/rdy_out     downstream handshake, data_out/last_out head entry (FWFT)
//   count               occupied entries, 0..DEPTH
//   almost_full         count >= AF_THRESH
//   almost_empty        count <= AE_THRESH
module axis_pkt_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 1,
    parameter int unsigned PKT_MODE  = 0,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             vld_in,
    output logic             rdy_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             last_in,
    output logic             vld_out,
    input  logic             rdy_out,
    output logic [WIDTH-1:0] data_out,
    output logic             last_out,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Elaboration-time parameter checks
    if (WIDTH < 1) begin : g_bad_width
        $error("axis_pkt_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("axis_pkt_fifo: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("axis_pkt_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("axis_pkt_fifo: AE_THRESH must be in 0..DEPTH-1");
    end
    if (CNT_W != $clog2(DEPTH + 1)) begin : g_bad_cnt_w
        $error("axis_pkt_fifo: CNT_W is derived and must not be overridden");
    end

    logic [WIDTH-1:0] mem_q      [DEPTH];
    logic             last_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic push, pop, full, not_empty, pkt_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);

    // rdy_in depends on registered state only: a full FIFO refuses even while popping.
    assign rdy_in = !full;

    // In packet mode output waits for a complete packet; a full FIFO releases anyway so a
    // packet longer than DEPTH cannot deadlock.
    assign pkt_ok  = (PKT_MODE == 0) || (pkt_cnt_q != '0) || full;
    assign vld_out = not_empty && pkt_ok;

    assign push = vld_in && rdy_in;
    assign pop  = vld_out && rdy_out;

    assign data_out = mem_q[rd_ptr_q];
    assign last_out = last_mem_q[rd_ptr_q];

    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pkt_cnt_d = pkt_cnt_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if ((push && last_in) && !(pop && last_out)) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else if ((pop && last_out) && !(push && last_in)) begin
            pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
        end
    end

    // rst and flush clear the same state; either one also voids that cycle's push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Storage is not reset; only pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem_q[wr_ptr_q]      <= data_in;
            last_mem_q[wr_ptr_q] <= last_in;
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
module tb_axis_pkt_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Stream-mode instance, DEPTH=5
    logic       s_flush = 0, s_vld_in = 0, s_last_in = 0, s_rdy_out = 0;
    logic [7:0] s_data_in = 0;
    logic       s_rdy_in, s_vld_out, s_last_out, s_af, s_ae;
    logic [7:0] s_data_out;
    logic [2:0] s_count;

    // Packet-mode instance, DEPTH=8
    logic       p_flush = 0, p_vld_in = 0, p_last_in = 0, p_rdy_out = 0;
    logic [7:0] p_data_in = 0;
    logic       p_rdy_in, p_vld_out, p_last_out, p_af, p_ae;
    logic [7:0] p_data_out;
    logic [3:0] p_count;

    axis_pkt_fifo #(
        .WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .PKT_MODE(0)
    ) u_str (
        .clk(clk), .rst(rst), .flush(s_flush),
        .vld_in(s_vld_in), .rdy_in(s_rdy_in), .data_in(s_data_in), .last_in(s_last_in),
        .vld_out(s_vld_out), .rdy_out(s_rdy_out), .data_out(s_data_out),
        .last_out(s_last_out), .count(s_count),
        .almost_full(s_af), .almost_empty(s_ae)
    );

    axis_pkt_fifo #(
        .WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .PKT_MODE(1)
    ) u_pkt (
        .clk(clk), .rst(rst), .flush(p_flush),
        .vld_in(p_vld_in), .rdy_in(p_rdy_in), .data_in(p_data_in), .last_in(p_last_in),
        .vld_out(p_vld_out), .rdy_out(p_rdy_out), .data_out(p_data_out),
        .last_out(p_last_out), .count(p_count),
        .almost_full(p_af), .almost_empty(p_ae)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs of a row are applied for one cycle; expected values describe the outputs
    // seen during that cycle, i.e. before the edge that acts on the inputs.
    typedef struct {
        logic       flush;
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic       rdy;
        logic       e_vld;
        logic       e_rdy;
        int         e_cnt;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_af;
        logic       e_ae;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fl, input logic v, input logic [7:0] d, input logic l,
                       input logic r, input logic ev, input logic er, input int ec,
                       input logic [7:0] ed, input logic el, input logic eaf,
                       input logic eae);
        vec_t x;
        x.flush = fl; x.vld = v; x.data = d; x.last = l; x.rdy = r;
        x.e_vld = ev; x.e_rdy = er; x.e_cnt = ec; x.e_data = ed; x.e_last = el;
        x.e_af = eaf; x.e_ae = eae;
        tbl.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pdrive(input logic v, input logic [7:0] d, input logic l, input logic r);
        p_vld_in = v; p_data_in = d; p_last_in = l; p_rdy_out = r;
    endtask

    initial begin
        //   fl v  data   l  r    ev er cnt data  el af ae
        // Fill to DEPTH with the consumer stalled; a 6th beat is refused
        add(0, 1, 8'hA0, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 8'hA1, 0, 0,   1, 1, 1, 8'hA0, 0, 0, 1);
        add(0, 1, 8'hA2, 0, 0,   1, 1, 2, 8'hA0, 0, 0, 0);
        add(0, 1, 8'hA3, 0, 0,   1, 1, 3, 8'hA0, 0, 0, 0);
        add(0, 1, 8'hA4, 1, 0,   1, 1, 4, 8'hA0, 0, 1, 0);
        add(0, 1, 8'hEE, 0, 0,   1, 0, 5, 8'hA0, 0, 1, 0);
        // Drain with producer active: full refuses B0, then steady count while popping
        add(0, 1, 8'hB0, 0, 1,   1, 0, 5, 8'hA0, 0, 1, 0);
        add(0, 1, 8'hB1, 0, 1,   1, 1, 4, 8'hA1, 0, 1, 0);
        add(0, 1, 8'hB2, 0, 1,   1, 1, 4, 8'hA2, 0, 1, 0);
        add(0, 1, 8'hB3, 1, 1,   1, 1, 4, 8'hA3, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1,   1, 1, 4, 8'hA4, 1, 1, 0);
        add(0, 0, 8'h00, 0, 1,   1, 1, 3, 8'hB1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 1,   1, 1, 2, 8'hB2, 0, 0, 0);
        add(0, 0, 8'h00, 0, 1,   1, 1, 1, 8'hB3, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);
        // Single beat latency with rdy_out held high
        add(0, 1, 8'h55, 1, 1,   0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1,   1, 1, 1, 8'h55, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);
        // Flush at count 4 with push and pop in the same cycle
        add(0, 1, 8'hC0, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 8'hC1, 0, 0,   1, 1, 1, 8'hC0, 0, 0, 1);
        add(0, 1, 8'hC2, 0, 0,   1, 1, 2, 8'hC0, 0, 0, 0);
        add(0, 1, 8'hC3, 0, 0,   1, 1, 3, 8'hC0, 0, 0, 0);
        add(1, 1, 8'hD0, 0, 1,   1, 1, 4, 8'hC0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1,   0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 8'hE0, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1,   1, 1, 1, 8'hE0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);
        // Simultaneous push and pop at count 1
        add(0, 1, 8'hF0, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 8'hF1, 1, 1,   1, 1, 1, 8'hF0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1,   1, 1, 1, 8'hF1, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0,   0, 1, 0, 8'h00, 0, 0, 1);

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.s_cnt", int'(s_count), 0);
        chk("rst.s_vld", int'(s_vld_out), 0);
        chk("rst.s_rdy", int'(s_rdy_in), 1);
        chk("rst.s_af", int'(s_af), 0);
        chk("rst.s_ae", int'(s_ae), 1);
        chk("rst.p_vld", int'(p_vld_out), 0);

        // Stream table
        for (int i = 0; i < tbl.size(); i++) begin
            s_flush = tbl[i].flush; s_vld_in = tbl[i].vld; s_data_in = tbl[i].data;
            s_last_in = tbl[i].last; s_rdy_out = tbl[i].rdy;
            chk($sformatf("s[%0d].vld", i), int'(s_vld_out), int'(tbl[i].e_vld));
            chk($sformatf("s[%0d].rdy_in", i), int'(s_rdy_in), int'(tbl[i].e_rdy));
            chk($sformatf("s[%0d].cnt", i), int'(s_count), tbl[i].e_cnt);
            chk($sformatf("s[%0d].af", i), int'(s_af), int'(tbl[i].e_af));
            chk($sformatf("s[%0d].ae", i), int'(s_ae), int'(tbl[i].e_ae));
            if (tbl[i].e_vld) begin
                chk($sformatf("s[%0d].data", i), int'(s_data_out), int'(tbl[i].e_data));
                chk($sformatf("s[%0d].last", i), int'(s_last_out), int'(tbl[i].e_last));
            end
            step();
        end
        s_flush = 0; s_vld_in = 0; s_rdy_out = 0;

        // Packet mode: 3-beat packet is held until LAST, then streams back-to-back
        pdrive(1, 8'h10, 0, 1); step();
        chk("p3.b0_vld", int'(p_vld_out), 0);
        chk("p3.b0_cnt", int'(p_count), 1);
        pdrive(1, 8'h11, 0, 1); step();
        chk("p3.b1_vld", int'(p_vld_out), 0);
        chk("p3.b1_cnt", int'(p_count), 2);
        pdrive(1, 8'h12, 1, 1); step();
        chk("p3.b2_vld", int'(p_vld_out), 1);
        chk("p3.b2_cnt", int'(p_count), 3);
        chk("p3.o0_data", int'(p_data_out), 8'h10);
        chk("p3.o0_last", int'(p_last_out), 0);
        pdrive(0, 8'h00, 0, 1); step();
        chk("p3.o1_vld", int'(p_vld_out), 1);
        chk("p3.o1_data", int'(p_data_out), 8'h11);
        chk("p3.o1_last", int'(p_last_out), 0);
        step();
        chk("p3.o2_vld", int'(p_vld_out), 1);
        chk("p3.o2_data", int'(p_data_out), 8'h12);
        chk("p3.o2_last", int'(p_last_out), 1);
        step();
        chk("p3.done_vld", int'(p_vld_out), 0);
        chk("p3.done_cnt", int'(p_count), 0);

        // Packet longer than DEPTH: full FIFO releases output without a LAST stored
        for (int i = 0; i < 8; i++) begin
            pdrive(1, 8'h90 + 8'(i), 0, 0); step();
            if (i < 7) chk($sformatf("p9.b%0d_vld", i), int'(p_vld_out), 0);
        end
        chk("p9.full_vld", int'(p_vld_out), 1);
        chk("p9.full_cnt", int'(p_count), 8);
        chk("p9.full_rdy", int'(p_rdy_in), 0);
        chk("p9.full_af", int'(p_af), 1);
        chk("p9.head", int'(p_data_out), 8'h90);
        pdrive(1, 8'h98, 1, 0); step();
        chk("p9.refused_cnt", int'(p_count), 8);
        pdrive(0, 8'h00, 0, 1); step();
        chk("p9.pop_cnt", int'(p_count), 7);
        chk("p9.pop_vld", int'(p_vld_out), 0);

        // Reset mid-packet with flush also high and a push pending
        rst = 1; p_flush = 1; pdrive(1, 8'h77, 1, 1); step();
        rst = 0; p_flush = 0; pdrive(0, 8'h00, 0, 0);
        chk("rst2.cnt", int'(p_count), 0);
        chk("rst2.vld", int'(p_vld_out), 0);
        chk("rst2.rdy", int'(p_rdy_in), 1);
        chk("rst2.af", int'(p_af), 0);
        chk("rst2.ae", int'(p_ae), 1);
        pdrive(1, 8'h60, 1, 0); step();
        chk("rst2.g_vld", int'(p_vld_out), 1);
        chk("rst2.g_cnt", int'(p_count), 1);
        chk("rst2.g_data", int'(p_data_out), 8'h60);
        chk("rst2.g_last", int'(p_last_out), 1);
        pdrive(0, 8'h00, 0, 1); step();
        chk("rst2.end_cnt", int'(p_count), 0);
        chk("rst2.end_vld", int'(p_vld_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
